// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register slave.
// Response codes, FSM state types and decode-width helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_t;

  function automatic int reg_aw(int nctrl, int nstat);
    return $clog2(nctrl + nstat) + 2;
  endfunction

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle with master/slave views.
// Data width is fixed at 32 bits.
interface axil_reg_slave_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder: RW control bank plus RO status bank.
// Independent single-outstanding write and read paths.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          NUM_CTRL   = 8,
  parameter int          NUM_STAT   = 8,
  parameter logic [31:0] CTRL_RST   = '0
) (
  input  logic                  s_axil_aclk,
  input  logic                  s_axil_rst_n,
  axil_reg_slave_if.slave       s_axil,
  output logic [NUM_CTRL*32-1:0] ctrl_o,
  output logic [NUM_CTRL-1:0]   ctrl_wr_pulse,
  input  logic [NUM_STAT*32-1:0] stat_i,
  output logic [NUM_STAT-1:0]   stat_rd_pulse
);

  localparam int IW = reg_aw(NUM_CTRL, NUM_STAT) - 2;
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] CTRL_END = WW'(NUM_CTRL);
  localparam logic [WW-1:0] REG_END  = WW'(NUM_CTRL + NUM_STAT);

  wstate_t w_state, w_state_n;
  logic aw_held, aw_held_n;
  logic w_held, w_held_n;
  logic [WW-1:0] awaddr_q, awaddr_n;
  logic [31:0] wdata_q, wdata_n;
  logic [3:0] wstrb_q, wstrb_n;
  logic awready, awready_n;
  logic wready, wready_n;
  logic bvalid, bvalid_n;
  logic [1:0] bresp, bresp_n;
  logic [31:0] ctrl_q [NUM_CTRL];
  logic [31:0] ctrl_n [NUM_CTRL];
  logic [NUM_CTRL-1:0] wr_pulse_n;

  rstate_t r_state, r_state_n;
  logic arready, arready_n;
  logic rvalid, rvalid_n;
  logic [1:0] rresp, rresp_n;
  logic [31:0] rdata, rdata_n;
  logic [NUM_STAT-1:0] rd_pulse_n;

  logic aw_hs, w_hs, ar_hs;
  logic [WW-1:0] wa_word, ra_word;
  logic [IW-1:0] wa_idx, ra_idx;
  logic in_ctrl, in_stat;
  logic unused_bits;

  assign unused_bits = ^{s_axil.awprot, s_axil.arprot,
                         s_axil.awaddr[1:0], s_axil.araddr[1:0]};

  assign aw_hs = awready & s_axil.awvalid;
  assign w_hs  = wready & s_axil.wvalid;
  assign ar_hs = arready & s_axil.arvalid;

  // Commit may coincide with either handshake, so decode the live value
  assign wa_word = aw_hs ? s_axil.awaddr[ADDR_WIDTH-1:2] : awaddr_q;
  assign wa_idx  = wa_word[IW-1:0];
  assign ra_word = s_axil.araddr[ADDR_WIDTH-1:2];
  assign ra_idx  = ra_word[IW-1:0];
  assign in_ctrl = ra_word < CTRL_END;
  assign in_stat = !in_ctrl && (ra_word < REG_END);

  always_comb begin
    w_state_n  = w_state;
    aw_held_n  = aw_held;
    w_held_n   = w_held;
    awaddr_n   = awaddr_q;
    wdata_n    = wdata_q;
    wstrb_n    = wstrb_q;
    awready_n  = awready;
    wready_n   = wready;
    bvalid_n   = bvalid;
    bresp_n    = bresp;
    ctrl_n     = ctrl_q;
    wr_pulse_n = '0;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_n = 1'b1;
          awaddr_n  = s_axil.awaddr[ADDR_WIDTH-1:2];
          awready_n = 1'b0;
        end else if (!aw_held) begin
          awready_n = 1'b1;
        end
        if (w_hs) begin
          w_held_n = 1'b1;
          wdata_n  = s_axil.wdata;
          wstrb_n  = s_axil.wstrb;
          wready_n = 1'b0;
        end else if (!w_held) begin
          wready_n = 1'b1;
        end
        if (aw_held_n && w_held_n) begin
          w_state_n = W_RESP;
          bvalid_n  = 1'b1;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          if (wa_word < CTRL_END) begin
            bresp_n = RESP_OKAY;
            for (int i = 0; i < NUM_CTRL; i++) begin
              if (wa_idx == IW'(i)) begin
                wr_pulse_n[i] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                  if (wstrb_n[b])
                    ctrl_n[i][8*b+:8] = wdata_n[8*b+:8];
                end
              end
            end
          end else begin
            bresp_n = RESP_SLVERR;
          end
        end
      end
      W_RESP: begin
        if (s_axil.bready) begin
          w_state_n = W_IDLE;
          bvalid_n  = 1'b0;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    r_state_n  = r_state;
    arready_n  = arready;
    rvalid_n   = rvalid;
    rresp_n    = rresp;
    rdata_n    = rdata;
    rd_pulse_n = '0;
    unique case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_n = R_RESP;
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rdata_n   = '0;
          unique case (1'b1)
            in_ctrl: begin
              rresp_n = RESP_OKAY;
              for (int i = 0; i < NUM_CTRL; i++) begin
                if (ra_idx == IW'(i))
                  rdata_n = ctrl_q[i];
              end
            end
            in_stat: begin
              rresp_n = RESP_OKAY;
              for (int j = 0; j < NUM_STAT; j++) begin
                if (ra_idx == IW'(NUM_CTRL + j)) begin
                  rdata_n       = stat_i[32*j+:32];
                  rd_pulse_n[j] = 1'b1;
                end
              end
            end
            default: rresp_n = RESP_SLVERR;
          endcase
        end else begin
          arready_n = 1'b1;
        end
      end
      R_RESP: begin
        if (s_axil.rready) begin
          r_state_n = R_IDLE;
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge s_axil_aclk or negedge s_axil_rst_n) begin
    if (!s_axil_rst_n) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awready       <= 1'b0;
      wready        <= 1'b0;
      bvalid        <= 1'b0;
      bresp         <= RESP_OKAY;
      ctrl_q        <= '{default: CTRL_RST};
      ctrl_wr_pulse <= '0;
      r_state       <= R_IDLE;
      arready       <= 1'b0;
      rvalid        <= 1'b0;
      rresp         <= RESP_OKAY;
      rdata         <= '0;
      stat_rd_pulse <= '0;
    end else begin
      w_state       <= w_state_n;
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      awaddr_q      <= awaddr_n;
      wdata_q       <= wdata_n;
      wstrb_q       <= wstrb_n;
      awready       <= awready_n;
      wready        <= wready_n;
      bvalid        <= bvalid_n;
      bresp         <= bresp_n;
      ctrl_q        <= ctrl_n;
      ctrl_wr_pulse <= wr_pulse_n;
      r_state       <= r_state_n;
      arready       <= arready_n;
      rvalid        <= rvalid_n;
      rresp         <= rresp_n;
      rdata         <= rdata_n;
      stat_rd_pulse <= rd_pulse_n;
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
    assign ctrl_o[32*g+:32] = ctrl_q[g];
  end

  assign s_axil.awready = awready;
  assign s_axil.wready  = wready;
  assign s_axil.bvalid  = bvalid;
  assign s_axil.bresp   = bresp;
  assign s_axil.arready = arready;
  assign s_axil.rvalid  = rvalid;
  assign s_axil.rresp   = rresp;
  assign s_axil.rdata   = rdata;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: directed table, concurrency and reset
// sequences, then random traffic against a register-array model.
module tb_axil_reg_slave;
  import axil_pkg::*;

  localparam int NC = 8;
  localparam int NS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_reg_slave_if #(.ADDR_WIDTH(32)) bus ();

  logic [NC*32-1:0] ctrl_o;
  logic [NC-1:0]    ctrl_wr_pulse;
  logic [NS*32-1:0] stat_i;
  logic [NS-1:0]    stat_rd_pulse;

  axil_reg_slave #(
    .ADDR_WIDTH(32),
    .NUM_CTRL(NC),
    .NUM_STAT(NS),
    .CTRL_RST(32'h0)
  ) dut (
    .s_axil_aclk(clk),
    .s_axil_rst_n(rst_n),
    .s_axil(bus),
    .ctrl_o(ctrl_o),
    .ctrl_wr_pulse(ctrl_wr_pulse),
    .stat_i(stat_i),
    .stat_rd_pulse(stat_rd_pulse)
  );

  int n_vec = 0;
  int n_fail = 0;
  logic [31:0] mdl [NC];

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          d0;
    int          d1;
    int          wait_c;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: handshake never completed", name);
  endtask

  function automatic logic [NC*32-1:0] mdl_flat();
    logic [NC*32-1:0] r;
    for (int i = 0; i < NC; i++) r[32*i+:32] = mdl[i];
    return r;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_d,
                          input int w_d, input int bwait,
                          input logic [1:0] exp_resp);
    bit aw_done = 0;
    bit w_done = 0;
    bit hs_aw, hs_w;
    int cyc = 0;
    int word = int'(addr[31:2]);
    logic [NC-1:0] exp_p = '0;
    if (word < NC) exp_p[word] = 1'b1;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done && cyc >= aw_d) begin
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
      end
      if (!w_done && cyc >= w_d) begin
        bus.wvalid = 1'b1;
        bus.wdata  = data;
        bus.wstrb  = strb;
      end
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (hs_aw) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (hs_w) begin w_done = 1; bus.wvalid = 1'b0; end
      if (aw_done && w_done && word < NC) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mdl[word][8*b+:8] = data[8*b+:8];
      end
      chk("bvalid", bus.bvalid, aw_done && w_done);
      chk("ctrl_o", ctrl_o, mdl_flat());
      chk("wr_pulse", ctrl_wr_pulse, (aw_done && w_done) ? exp_p : '0);
      if (!(aw_done && w_done)) begin
        if (aw_done) chk("awready_held", bus.awready, 1'b0);
        if (w_done) chk("wready_held", bus.wready, 1'b0);
      end
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      timeout("write");
      return;
    end
    chk("bresp", bus.bresp, exp_resp);
    for (int k = 0; k < bwait; k++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", bus.bvalid, 1'b1);
      chk("bresp_hold", bus.bresp, exp_resp);
      chk("awready_wait", bus.awready, 1'b0);
      chk("wready_wait", bus.wready, 1'b0);
      chk("wr_pulse_off", ctrl_wr_pulse, '0);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    chk("bvalid_done", bus.bvalid, 1'b0);
    chk("awready_back", bus.awready, 1'b1);
    chk("wready_back", bus.wready, 1'b1);
    chk("wr_pulse_end", ctrl_wr_pulse, '0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_d,
                         input int rwait, input logic [1:0] exp_resp,
                         input logic [31:0] exp_data);
    bit done = 0;
    bit hs;
    int cyc = 0;
    int word = int'(addr[31:2]);
    logic [NS-1:0] exp_sp = '0;
    if (word >= NC && word < NC + NS) exp_sp[word-NC] = 1'b1;
    while (!done && cyc < 40) begin
      if (cyc >= ar_d) begin
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
      end
      hs = bus.arvalid && bus.arready;
      @(posedge clk); #1;
      if (hs) begin done = 1; bus.arvalid = 1'b0; end
      chk("rvalid", bus.rvalid, done);
      chk("rd_pulse", stat_rd_pulse, done ? exp_sp : '0);
      cyc++;
    end
    if (!done) begin
      timeout("read");
      return;
    end
    chk("rdata", bus.rdata, exp_data);
    chk("rresp", bus.rresp, exp_resp);
    for (int k = 0; k < rwait; k++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", bus.rvalid, 1'b1);
      chk("rdata_hold", bus.rdata, exp_data);
      chk("rresp_hold", bus.rresp, exp_resp);
      chk("arready_wait", bus.arready, 1'b0);
      chk("rd_pulse_off", stat_rd_pulse, '0);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    chk("rvalid_done", bus.rvalid, 1'b0);
    chk("arready_back", bus.arready, 1'b1);
    chk("rd_pulse_end", stat_rd_pulse, '0);
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] addr,
                                           output logic [1:0] resp);
    int word = int'(addr[31:2]);
    resp = RESP_OKAY;
    if (word < NC) return mdl[word];
    if (word < NC + NS) return stat_i[32*(word-NC)+:32];
    resp = RESP_SLVERR;
    return 32'h0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_d, a, d;
    logic [1:0]  exp_r;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    for (int i = 0; i < NC; i++) mdl[i] = 32'h0;
    stat_i = '0;
    stat_i[31:0] = 32'hA5A5A5A5;
    stat_i[7*32+:32] = 32'h7777_0007;

    vt[0]  = '{0, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, RESP_OKAY, 0};
    vt[1]  = '{0, 32'h00, 32'h12345678, 4'h3, 3, 0, 0, RESP_OKAY, 0};
    vt[2]  = '{1, 32'h20, 0, 0, 0, 0, 0, RESP_OKAY, 32'hA5A5A5A5};
    vt[3]  = '{0, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 1, 0, RESP_SLVERR, 0};
    vt[4]  = '{1, 32'h40, 0, 0, 0, 0, 0, RESP_SLVERR, 32'h0};
    vt[5]  = '{1, 32'h04, 0, 0, 1, 0, 5, RESP_OKAY, 32'hDEADBEEF};
    vt[6]  = '{0, 32'h0B, 32'hCAFEF00D, 4'hF, 1, 2, 5, RESP_OKAY, 0};
    vt[7]  = '{0, 32'h08, 32'h11111111, 4'h0, 0, 0, 1, RESP_OKAY, 0};
    vt[8]  = '{1, 32'h08, 0, 0, 0, 0, 0, RESP_OKAY, 32'hCAFEF00D};
    vt[9]  = '{1, 32'h3C, 0, 0, 0, 0, 2, RESP_OKAY, 32'h7777_0007};
    vt[10] = '{0, 32'h3C, 32'h55555555, 4'hF, 0, 0, 0, RESP_SLVERR, 0};
    vt[11] = '{1, 32'h01, 0, 0, 0, 0, 0, RESP_OKAY, 32'h00005678};

    #12;
    chk("rst_awready", bus.awready, 1'b0);
    chk("rst_wready", bus.wready, 1'b0);
    chk("rst_arready", bus.arready, 1'b0);
    chk("rst_bvalid", bus.bvalid, 1'b0);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_resp", {bus.bresp, bus.rresp}, 4'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_ctrl", ctrl_o, '0);
    chk("rst_pulses", {ctrl_wr_pulse, stat_rd_pulse}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_awready", bus.awready, 1'b1);
    chk("rel_wready", bus.wready, 1'b1);
    chk("rel_arready", bus.arready, 1'b1);

    for (int v = 0; v < 12; v++) begin
      if (vt[v].rd)
        do_read(vt[v].addr, vt[v].d0, vt[v].wait_c, vt[v].resp, vt[v].rdata);
      else
        do_write(vt[v].addr, vt[v].data, vt[v].strb, vt[v].d0, vt[v].d1,
                 vt[v].wait_c, vt[v].resp);
    end

    exp_d = mdl[3];
    fork
      do_write(32'h0C, 32'h33333333, 4'hF, 0, 0, 1, RESP_OKAY);
      do_read(32'h0C, 0, 0, RESP_OKAY, exp_d);
    join
    do_read(32'h0C, 0, 0, RESP_OKAY, 32'h33333333);

    bus.awvalid = 1'b1; bus.awaddr = 32'h0;
    bus.wvalid = 1'b1; bus.wdata = 32'h11223344; bus.wstrb = 4'hF;
    bus.arvalid = 1'b1; bus.araddr = 32'h24;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    mdl[0] = 32'h11223344;
    chk("mid_bvalid", bus.bvalid, 1'b1);
    chk("mid_rvalid", bus.rvalid, 1'b1);
    chk("mid_ctrl", ctrl_o, mdl_flat());
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NC; i++) mdl[i] = 32'h0;
    chk("arst_bvalid", bus.bvalid, 1'b0);
    chk("arst_rvalid", bus.rvalid, 1'b0);
    chk("arst_ctrl", ctrl_o, mdl_flat());
    chk("arst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
    chk("arst_pulses", {ctrl_wr_pulse, stat_rd_pulse}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_write(32'h1C, 32'h0BADF00D, 4'hC, 1, 0, 0, RESP_OKAY);
    do_read(32'h1C, 0, 0, RESP_OKAY, 32'h0BAD0000);

    for (int t = 0; t < 200; t++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h40 + $urandom_range(0, 63)
                                      : $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 3) == 0)
          for (int j = 0; j < NS; j++) stat_i[32*j+:32] = $urandom;
        exp_d = mdl_read(a, exp_r);
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 3), exp_r, exp_d);
      end else begin
        d = $urandom;
        exp_r = (a[31:2] < NC) ? RESP_OKAY : RESP_SLVERR;
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), exp_r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
